// File: rtl/gol_pkg.sv
// Grid geometry, scan FSM encoding and a bit-lookup helper shared by the life display path.
package gol_pkg;
    localparam int GRID_W = 16;
    localparam int GRID_H = 16;

    typedef enum logic [1:0] {FRAME, SHIFT, BLANK, LATCH} scan_state_t;

    typedef logic [GRID_W*GRID_H-1:0] grid_t;

    // Row r occupies bits [16r+15:16r], so {row, col} is the flat bit index.
    function automatic logic grid_bit(input grid_t g, input logic [3:0] row, input logic [3:0] col);
        return g[{row, col}];
    endfunction
endpackage

// File: rtl/scan_clk_div.sv
// Serial bit timer: sclk low for DIV cycles then high for DIV cycles; o_bit_done marks the last high cycle.
// Held cleared (sclk low, counter zero) whenever i_en is low, so every enable starts a clean bit.
module scan_clk_div #(
    parameter int DIV = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_en,
    output logic o_sclk,
    output logic o_bit_done
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_phase;
    logic          w_last;

    assign w_last = (r_cnt == CW'(DIV - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset || !i_en) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_last) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_sclk     = r_phase;
    assign o_bit_done = i_en && r_phase && w_last;
endmodule

// File: rtl/gol_grid_scanner.sv
// Buffers one life grid per frame_valid/frame_ready handshake and row-scans it to an LED matrix; first sdata 1 cycle after accept.
// frame_ready is high only in FRAME so frames never tear; GOL_ROW_BLANK_EN adds BLANK cycles of oe=0 before each latch.
module gol_grid_scanner #(
    parameter int DIV   = 2,
    parameter int BLANK = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [255:0] display,
    input  logic         frame_valid,
    output logic         frame_ready,
    output logic         sdata,
    output logic         sclk,
    output logic         slatch,
    output logic [3:0]   row_sel,
    output logic         oe
);
    import gol_pkg::*;

    if (DIV < 1 || BLANK < 1) begin : g_bad_param
        $error("gol_grid_scanner: DIV and BLANK must both be >= 1");
    end

    scan_state_t r_state;
    grid_t       r_fbuf;
    logic        r_have_frame;
    logic [3:0]  r_row;
    logic [3:0]  r_bit;
    logic        r_frame_ready;
    logic        r_sdata;
    logic        r_slatch;
    logic [3:0]  r_row_sel;
    logic        r_oe;
    logic        w_bit_done;
    logic [3:0]  w_next_bit;
    logic [3:0]  w_next_row;
`ifdef GOL_ROW_BLANK_EN
    localparam int BW = (BLANK > 1) ? $clog2(BLANK) : 1;
    logic [BW-1:0] r_blank;
`endif

    assign w_next_bit = r_bit + 4'd1;
    assign w_next_row = r_row + 4'd1;

    scan_clk_div #(.DIV(DIV)) u_clk_div (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_en       (r_state == SHIFT),
        .o_sclk     (sclk),
        .o_bit_done (w_bit_done)
    );

    // Not reset: contents are meaningless until have_frame is set.
    always_ff @(posedge clk) begin
        if (r_state == FRAME && frame_valid) begin
            r_fbuf <= display;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= FRAME;
            r_have_frame  <= 1'b0;
            r_row         <= 4'd0;
            r_bit         <= 4'd0;
            r_frame_ready <= 1'b1;
            r_sdata       <= 1'b0;
            r_slatch      <= 1'b0;
            r_row_sel     <= 4'd0;
            r_oe          <= 1'b0;
`ifdef GOL_ROW_BLANK_EN
            r_blank       <= '0;
`endif
        end else begin
            r_slatch <= 1'b0;
            case (r_state)
                FRAME: begin
                    r_row <= 4'd0;
                    r_bit <= 4'd0;
                    if (frame_valid) begin
                        r_have_frame  <= 1'b1;
                        r_sdata       <= grid_bit(display, 4'd0, 4'hF);
                        r_frame_ready <= 1'b0;
                        r_state       <= SHIFT;
                    end else if (r_have_frame) begin
                        r_sdata       <= grid_bit(r_fbuf, 4'd0, 4'hF);
                        r_frame_ready <= 1'b0;
                        r_state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_bit_done) begin
                        if (r_bit == 4'd15) begin
`ifdef GOL_ROW_BLANK_EN
                            r_oe    <= 1'b0;
                            r_blank <= '0;
                            r_state <= gol_pkg::BLANK;
`else
                            r_slatch  <= 1'b1;
                            r_row_sel <= r_row;
                            r_state   <= LATCH;
`endif
                        end else begin
                            // Column bits go out MSB first: bit index 15-n is ~n.
                            r_bit   <= w_next_bit;
                            r_sdata <= grid_bit(r_fbuf, r_row, ~w_next_bit);
                        end
                    end
                end
`ifdef GOL_ROW_BLANK_EN
                gol_pkg::BLANK: begin
                    if (r_blank == BW'(BLANK - 1)) begin
                        r_slatch  <= 1'b1;
                        r_row_sel <= r_row;
                        r_state   <= LATCH;
                    end else begin
                        r_blank <= r_blank + 1'b1;
                    end
                end
`endif
                LATCH: begin
                    r_oe  <= 1'b1;
                    r_bit <= 4'd0;
                    if (r_row == 4'd15) begin
                        r_frame_ready <= 1'b1;
                        r_state       <= FRAME;
                    end else begin
                        r_row   <= w_next_row;
                        r_sdata <= grid_bit(r_fbuf, w_next_row, 4'hF);
                        r_state <= SHIFT;
                    end
                end
                default: begin
                    r_frame_ready <= 1'b1;
                    r_state       <= FRAME;
                end
            endcase
        end
    end

    assign frame_ready = r_frame_ready;
    assign sdata       = r_sdata;
    assign slatch      = r_slatch;
    assign row_sel     = r_row_sel;
    assign oe          = r_oe;
endmodule

// File: doc/gol_grid_scanner.md
# gol_grid_scanner

Display-side consumer of the 16×16 Game-of-Life FSM's 256-bit `display` grid. It accepts one full grid per frame through a valid/ready handshake and holds it in a frame buffer. It then drives a row-multiplexed LED matrix: each row is shifted out serially to a column shift register, latched, and selected with a 4-bit row address. It sits between the life FSM and the board pins and refreshes continuously from the buffered frame until the next frame is accepted.

## Interface
- `DIV`, 2: `sclk` half-period in `clk` cycles; legal range ≥1.
- `BLANK`, 4: blanking cycles per row; used only when the macro is defined; legal range ≥1.

- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `display` in 256: grid; row r = `display[16r+15:16r]`, row 0 = bits [15:0].
- `frame_valid` in 1: `display` holds a new frame.
- `frame_ready` out 1: scanner is at a frame boundary and captures `display` this cycle if `frame_valid`.
- `sdata` out 1: serial column data, MSB of the row first.
- `sclk` out 1: shift clock; the column register samples on the rising edge.
- `slatch` out 1: one-cycle pulse that transfers the shifted row to the column outputs.
- `row_sel` out 4: active row address.
- `oe` out 1: matrix output enable, active-high.

## Operation
- FSM states, all registered:
  - FRAME: `frame_ready`=1.
    - On `frame_valid`, capture `display` into `fbuf`, set `have_frame`, row counter := 0, go to SHIFT.
    - With no `frame_valid` and `have_frame`=1, rescan `fbuf` from row 0 and go to SHIFT.
    - With no `frame_valid` and `have_frame`=0, stay in FRAME.
    - FRAME always lasts at least 1 cycle.
  - SHIFT: bits 15 down to 0 of the current row.
    - Per bit: `sdata` is set and `sclk`=0 for DIV cycles, then `sclk`=1 for DIV cycles.
    - `sdata` is stable across the whole bit.
    - Total 32·DIV cycles, then go to BLANK (macro) or LATCH.
  - BLANK (macro only): `oe`=0 for BLANK cycles, then LATCH.
  - LATCH: 1 cycle.
    - `slatch`=1, `row_sel` := row counter, `sclk`=0.
    - Row 15 → FRAME; otherwise increment the row counter and go to SHIFT.
- `oe` goes to 1 on the cycle after the first LATCH following `have_frame` being set.
- The display of row r overlaps the shift of row r+1.
- `frame_ready` is high only in FRAME, so a frame is never torn mid-scan.
- `frame_valid` outside FRAME is ignored; there is no back-pressure on the producer beyond `frame_ready`.
- Row and bit counters are 4 bits wide. The row counter does not wrap past 15; FRAME resets it.

## Timing
- Reset values (the cycle after `reset` is sampled high):
  - state FRAME, `frame_ready`=1.
  - `sdata`=0, `sclk`=0, `slatch`=0, `row_sel`=0, `oe`=0.
  - `have_frame`=0, all counters 0.
  - `fbuf` is not cleared but is unused.
- Reset mid-scan: all outputs return to the reset values in the next cycle. No further output occurs until a new frame is accepted.
- Latency: `frame_valid`&`frame_ready` at cycle t puts the first `sdata` (row0[15]) at t+1, with `sclk` low.
- Row period: 32·DIV+1 cycles, or 32·DIV+BLANK+1 with the macro.
- Frame period: 16·row period + 1 (FRAME).
- With DIV=2 and no macro: row 65 cycles, frame 1041 cycles.
- The first `slatch` occurs at t+65; the FRAME after row 15 occurs at t+1041.
- `frame_valid` high in FRAME while `have_frame`=1: the new frame replaces `fbuf`, and that same cycle still counts as the 1-cycle FRAME.

## Configuration
- `GOL_ROW_BLANK_EN` defined: inserts the BLANK state. `oe`=0 during BLANK and LATCH and returns to 1 the cycle after LATCH, to suppress ghosting.
- Not defined: no BLANK state. `oe` stays 1 continuously once raised and drops only on reset.

## Structure
- Shared package `gol_pkg`:
  - `GRID_W`=16 and `GRID_H`=16.
  - `scan_state_t` enum: FRAME, SHIFT, BLANK, LATCH.
  - `grid_t` typedef (logic [GRID_W·GRID_H-1:0]).
- One sub-module, `scan_clk_div`, generates DIV-based `sclk` phases and a bit-done strobe. It is enabled only in SHIFT.

## Test plan
- Reset, with `frame_valid` held 0 for 200 cycles → `frame_ready`=1, `oe`=0, no `sclk` edges, no `slatch`.
- Frame with `display`[15:0]=16'h2000 (row 0), DIV=2, accepted at t:
  - 16 `sclk` rising edges; `sdata` sampled = 0010000000000000.
  - `slatch` at t+65 with `row_sel`=0.
  - `oe` goes to 1 at t+66.
- Same frame left running with `frame_valid`=0: FRAME recurs every 1041 cycles and the scan repeats identically, showing rescan from the buffer.
- Change `display` and pulse `frame_valid` mid-scan (row 7) → ignored. The new data appears only in the scan after the next FRAME, and `row_sel` visits 0..15 in order.
- Assert `reset` during row 9 SHIFT → next cycle all outputs are at reset values and `have_frame`=0. Scanning stays idle until a new `frame_valid`.
- Macro defined, BLANK=4 → `oe`=0 for exactly 5 cycles (4 BLANK + LATCH) per row, and the row period is 69 cycles.
